img_rx_ctrl: RTL

- Frame loader that sits between the UART receiver and the VGA framebuffer in the image-receiver design.
- Consumes the receiver's byte strobe and data, waits for a sync byte, then writes exactly one frame of pixel bytes into framebuffer RAM at sequential addresses.
- Reports frame completion, busy status and a sticky timeout error.
- A receive timeout aborts partial frames so that the next sync byte always starts a clean frame.

---
 rtl/img_rx_ctrl_if.sv | 28 ++
 rtl/img_rx_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/img_rx_ctrl_if.sv
// rtl/img_rx_ctrl_if.sv - UART byte input and framebuffer write bus for the frame loader
interface img_rx_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // master: the loader, which consumes bytes and drives framebuffer writes
    modport master (
        input  rx_rdy,
        input  rx_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    // slave: the surrounding receiver/framebuffer side
    modport slave (
        output rx_rdy,
        output rx_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/img_rx_ctrl.sv
// rtl/img_rx_ctrl.sv - sync-triggered frame loader from UART bytes into framebuffer RAM
module img_rx_ctrl #(
    parameter int             IMG_W       = 64,
    parameter int             IMG_H       = 48,
    parameter int             ADDR_W      = 12,
    parameter logic [7:0]     SYNC_BYTE   = 8'hA5,
    parameter int             TIMEOUT_CYC = 120000
) (
    input  logic                 clk,
    input  logic                 reset,
    img_rx_ctrl_if.master        bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err,
    output logic [7:0]           frame_cnt
);
    localparam int                NPIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
    localparam int                TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic [TW-1:0]     timer, timer_nx;

    logic              wr_en_q, wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nx;
    logic [7:0]        wr_data_q, wr_data_nx;
    logic              busy_nx, done_nx, err_nx;
    logic [7:0]        cnt_nx;

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    // Next-state and next-output decode; every output is registered from these values
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        timer_nx   = timer;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr_q;
        wr_data_nx = wr_data_q;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        err_nx     = err;
        cnt_nx     = frame_cnt;
        case (state)
            IDLE: begin
                if (bus.rx_rdy && bus.rx_data == SYNC_BYTE) begin
                    state_nx = RECV;
                    idx_nx   = '0;
                    timer_nx = '0;
                    err_nx   = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            RECV: begin
                busy_nx = 1'b1;
                if (bus.rx_rdy) begin
                    // A byte arriving on the expiry cycle still wins over the timeout
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = idx;
                    wr_data_nx = bus.rx_data;
                    timer_nx   = '0;
                    idx_nx     = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        cnt_nx   = frame_cnt + 8'd1;
                    end
                end else if (timer == TO_LAST) begin
                    // Abort the partial frame so the next sync starts cleanly
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    err_nx   = 1'b1;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            DONE: begin
                // Bytes arriving here are dropped; UART spacing makes this harmless
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            timer      <= timer_nx;
            wr_en_q    <= wr_en_nx;
            wr_addr_q  <= wr_addr_nx;
            wr_data_q  <= wr_data_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
            err        <= err_nx;
            frame_cnt  <= cnt_nx;
        end
    end
endmodule
